// File: rtl/lapido_mem_arbiter_if.sv
// Bus bundle between the 5-stage core (IF and MEM requesters), the arbiter and
// the external single-port memory. The arbiter uses the slave modport; the environment uses master.
interface lapido_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Instruction-fetch requester
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ack;

  // Data (MEM stage) requester
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  // External memory port
  logic                  ext_req;
  logic                  ext_we;
  logic [ADDR_WIDTH-1:0] ext_addr;
  logic [DATA_WIDTH-1:0] ext_wdata;
  logic [DATA_WIDTH-1:0] ext_rdata;
  logic                  ext_ready;

  // Status
  logic                  bus_err;
  logic                  stall_pipeline;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_rdata, ext_ready,
    output bus_err, stall_pipeline
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_rdata, ext_ready,
    input  bus_err, stall_pipeline
  );
endinterface

// File: rtl/lapido_mem_arbiter.sv
// Shares one single-port memory between IF and MEM with data priority and an anti-starvation streak.
// Optional BUSY-state abort timer is enabled by defining LAPIDO_ARB_TIMEOUT_EN.
module lapido_mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_DSTREAK = 4
`ifdef LAPIDO_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT     = 255
`endif
) (
  input logic                 clk,
  input logic                 rst,
  lapido_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2,
    RESP     = 2'd3
  } state_e;

  localparam int                  STREAK_W   = $clog2(MAX_DSTREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

`ifdef LAPIDO_ARB_TIMEOUT_EN
  localparam int                 TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
`endif

  state_e                state_q, state_d;
  logic                  ext_req_q, ext_req_d;
  logic                  ext_we_q, ext_we_d;
  logic [ADDR_WIDTH-1:0] ext_addr_q, ext_addr_d;
  logic [DATA_WIDTH-1:0] ext_wdata_q, ext_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  mem_ack_q, mem_ack_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;

  logic if_forced;
  logic grant_mem;
  logic grant_if;
  logic xfer_done;

  // IF overrides the data-side priority once MEM has won MAX_DSTREAK times in a row while IF waited.
  assign if_forced = bus.if_req && (streak_q == STREAK_MAX);
  assign grant_mem = bus.mem_req && !if_forced;
  assign grant_if  = bus.if_req && !grant_mem;

`ifdef LAPIDO_ARB_TIMEOUT_EN
  logic                 bus_err_q, bus_err_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  assign xfer_done = bus.ext_ready || (timer_q == TIMER_LAST);
`else
  assign xfer_done = bus.ext_ready;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d = BUSY_MEM;
        end else if (grant_if) begin
          state_d = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (xfer_done) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    streak_d    = streak_q;
`ifdef LAPIDO_ARB_TIMEOUT_EN
    bus_err_d   = 1'b0;
    timer_d     = timer_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_mem) begin
          ext_req_d   = 1'b1;
          ext_we_d    = bus.mem_we;
          ext_addr_d  = bus.mem_addr;
          ext_wdata_d = bus.mem_wdata;
          if (!bus.if_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
`ifdef LAPIDO_ARB_TIMEOUT_EN
          timer_d = '0;
`endif
        end else if (grant_if) begin
          ext_req_d  = 1'b1;
          ext_we_d   = 1'b0;
          ext_addr_d = bus.if_addr;
          streak_d   = '0;
`ifdef LAPIDO_ARB_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end

      BUSY_IF, BUSY_MEM: begin
        if (bus.ext_ready) begin
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
          if (state_q == BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.ext_rdata;
          end else begin
            mem_ack_d = 1'b1;
            // Writes leave the last read result visible to the MEM stage.
            if (!ext_we_q) begin
              mem_rdata_d = bus.ext_rdata;
            end
          end
        end
`ifdef LAPIDO_ARB_TIMEOUT_EN
        else if (timer_q == TIMER_LAST) begin
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = '0;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
`endif
      end

      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      streak_q    <= '0;
    end else begin
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      streak_q    <= streak_d;
    end
  end

`ifdef LAPIDO_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      bus_err_q <= bus_err_d;
      timer_q   <= timer_d;
    end
  end

  assign bus.bus_err = bus_err_q;
`else
  assign bus.bus_err = 1'b0;
`endif

  assign bus.ext_req   = ext_req_q;
  assign bus.ext_we    = ext_we_q;
  assign bus.ext_addr  = ext_addr_q;
  assign bus.ext_wdata = ext_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_ack   = mem_ack_q;

  // Freeze the pipeline while either requester waits; an acked requester is released in RESP.
  assign bus.stall_pipeline = (bus.if_req && !if_ack_q) || (bus.mem_req && !mem_ack_q);

endmodule
